data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-master arbiter that shares the single-port data RAM between the processor's load/store path and an external loader/DMA port. The processor has fixed priority, and a starvation counter bounds how long the external port can wait. The block sits between the ALU-result/ReadData2 datapath and the DataMemory instance and drives a stall to the processor while its access is pending. One access completes per cycle. Each access is acknowledged in the cycle it is performed.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_BURST, 4, longest wait (in grants to the CPU) the external port tolerates before it is forced through; legal values are 1..15
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cpu_req / cpu_we  input  1  CPU access request / write enable
- cpu_addr  input  ADDR_WIDTH  CPU address (already offset to RAM base)
- cpu_wdata  input  DATA_WIDTH  CPU store data
- cpu_rdata  output  DATA_WIDTH  CPU load data, valid while cpu_ack=1
- cpu_ack  output  1  CPU access performed this cycle
- cpu_stall  output  1  cpu_req & ~cpu_ack
- ext_req / ext_we / ext_addr / ext_wdata  input  as CPU  external request
- ext_rdata / ext_ack  output  as CPU  external response
- mem_re / mem_we  output  1  RAM read / write strobes
- mem_addr / mem_wdata  output  ADDR_WIDTH / DATA_WIDTH  RAM address / data
- mem_rdata  input  DATA_WIDTH  RAM combinational read data
- cpu_wait_cnt / ext_wait_cnt  output  16  stall-cycle statistics (see Configuration)

## Operation
- FSM states: IDLE, GNT_CPU, GNT_EXT. The state register is the only grant source.
- mem_* signals are combinational muxes of the owning master's inputs.
  - mem_re = owner's ~we; mem_we = owner's we.
  - In IDLE, mem_re, mem_we, mem_addr and mem_wdata are all 0.
- In a grant state, the owner's ack=1 and its rdata = mem_rdata. The other ack is 0 and the other rdata is 0.
- Requester rule: hold req, we, addr and wdata stable until ack. req still high on the ack edge counts as a new request, so the requester must present the next address in the following cycle.
- Next-state decision, taken at each rising edge from sampled req lines:
  - Neither master requesting -> IDLE.
  - Only one master requesting -> that master.
  - Both requesting -> GNT_EXT if starve_cnt==MAX_BURST and state!=GNT_EXT; otherwise GNT_CPU.
- starve_cnt (4-bit) is updated at each edge:
  - Cleared when the next state is GNT_EXT.
  - Otherwise incremented when ext_req=1, saturating at MAX_BURST.
  - Otherwise held.
- There are no wait states inside the arbiter. RAM writes commit at the end of the grant cycle.

## Timing
- Reset values: state IDLE, starve_cnt 0, cpu_ack/ext_ack 0, all mem_* 0, rdata outputs 0, stall counters 0.
- Reset is asynchronous: asserting it mid-grant drops ack and mem_we immediately, so no partial write is committed.
- Latency: req rising in cycle N (state IDLE) -> ack in cycle N+1.
- Throughput: back-to-back requests from one master are acked every cycle.
- With both masters requesting continuously, CPU worst-case wait is 1 cycle; EXT worst-case wait is MAX_BURST+1 cycles.
- cpu_stall is combinational from cpu_req and state, with no register stage.

## Configuration
- ARB_STATS_EN defined:
  - cpu_wait_cnt increments on each cycle with cpu_req & ~cpu_ack.
  - ext_wait_cnt increments on each cycle with ext_req & ~ext_ack.
  - Both counters saturate at 16'hFFFF and clear only on reset.
- ARB_STATS_EN undefined: both counter outputs are tied to 16'h0000 and no counter flops are synthesized. Arbitration behaviour is identical in both builds.

## Test plan
- CPU only: reset, then cpu_req=1, cpu_we=1, addr 0x8, wdata 0xDEADBEEF. Require ack at +1 cycle and mem_we=1 for exactly one cycle. A following read of 0x8 must return cpu_rdata 0xDEADBEEF with cpu_ack=1.
- Contention with MAX_BURST=4: both masters hold req from IDLE. The grant sequence must be CPU, CPU, CPU, CPU, EXT, CPU, CPU, CPU, CPU, EXT. cpu_stall must be 1 only in the EXT cycles.
- EXT only, back-to-back: ext_req held 8 cycles with incrementing addresses 0x0..0x1C. Require ext_ack on cycles 1..8, mem_addr following ext_addr each cycle, and starve_cnt staying 0.
- Reset mid-write: assert reset low during a GNT_CPU write cycle before the edge. Require mem_we to fall within the same cycle, RAM contents unchanged, and state IDLE after reset release.
- Stats, with ARB_STATS_EN: the contention scenario for 10 grants must give cpu_wait_cnt=3 (1 idle + 2 EXT cycles) and ext_wait_cnt=9. With ARB_STATS_EN undefined, both must read 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU has fixed priority, EXT is forced through after MAX_BURST lost grants.
// Optional stall statistics are built only when ARB_STATS_EN is defined.
//
// state   | meaning
// IDLE    | no grant, RAM strobes low
// GNT_CPU | CPU owns the RAM this cycle and is acked
// GNT_EXT | external port owns the RAM this cycle and is acked
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_ack,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           cpu_wait_cnt,
  output logic [15:0]           ext_wait_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_EXT} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;

  always_comb begin
    state_nxt = IDLE;
    if (cpu_req && ext_req) begin
      if (starve_cnt == MAX_B && state != GNT_EXT) state_nxt = GNT_EXT;
      else                                         state_nxt = GNT_CPU;
    end else if (cpu_req) begin
      state_nxt = GNT_CPU;
    end else if (ext_req) begin
      state_nxt = GNT_EXT;
    end

    starve_nxt = starve_cnt;
    if (state_nxt == GNT_EXT)                 starve_nxt = 4'd0;
    else if (ext_req && starve_cnt != MAX_B)  starve_nxt = starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // RAM port and responses follow the state register directly, so reset kills a write immediately
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    ext_ack   = 1'b0;
    cpu_rdata = '0;
    ext_rdata = '0;
    case (state)
      GNT_CPU: begin
        mem_re    = ~cpu_we;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = 1'b1;
        cpu_rdata = mem_rdata;
      end
      GNT_EXT: begin
        mem_re    = ~ext_we;
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        ext_ack   = 1'b1;
        ext_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

`ifdef ARB_STATS_EN
  logic [15:0] cpu_wait_q, ext_wait_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_wait_q <= 16'h0000;
      ext_wait_q <= 16'h0000;
    end else begin
      if (cpu_req && !cpu_ack && cpu_wait_q != 16'hFFFF) cpu_wait_q <= cpu_wait_q + 16'h0001;
      if (ext_req && !ext_ack && ext_wait_q != 16'hFFFF) ext_wait_q <= ext_wait_q + 16'h0001;
    end
  end

  assign cpu_wait_cnt = cpu_wait_q;
  assign ext_wait_cnt = ext_wait_q;
`else
  assign cpu_wait_cnt = 16'h0000;
  assign ext_wait_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: owns the RAM, models slot ownership at the transaction level and checks every cycle.
module tb_data_mem_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [31:0] ext_addr = '0, ext_wdata = '0;
  logic [31:0] ext_rdata;
  logic        ext_ack;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] cpu_wait_cnt, ext_wait_cnt;

  int checks = 0;
  int failures = 0;

  data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_wait_cnt(cpu_wait_cnt), .ext_wait_cnt(ext_wait_cnt)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, write committed at the clock edge
  logic [31:0] ram [0:63];
  initial for (int i = 0; i < 64; i++) ram[i] = 32'h0;
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the slot, and how many edges EXT has been asking without winning
  int m_owner = 0;
  int m_passed = 0;
  int m_cpu_wait = 0, m_ext_wait = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner = 0; m_passed = 0; m_cpu_wait = 0; m_ext_wait = 0;
    end else begin
      int nxt;
      if (cpu_req && m_owner != 1 && m_cpu_wait < 65535) m_cpu_wait = m_cpu_wait + 1;
      if (ext_req && m_owner != 2 && m_ext_wait < 65535) m_ext_wait = m_ext_wait + 1;
      if (cpu_req && ext_req) nxt = (m_passed >= MAX_BURST && m_owner != 2) ? 2 : 1;
      else if (cpu_req) nxt = 1;
      else if (ext_req) nxt = 2;
      else nxt = 0;
      if (nxt == 2) m_passed = 0;
      else if (ext_req) m_passed = (m_passed + 1 > MAX_BURST) ? MAX_BURST : m_passed + 1;
      m_owner = nxt;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, ed, erd;
    logic        ere, ewe;
    ea = 0; ed = 0; ere = 0; ewe = 0;
    if (m_owner == 1) begin ea = cpu_addr; ed = cpu_wdata; ewe = cpu_we; ere = !cpu_we; end
    if (m_owner == 2) begin ea = ext_addr; ed = ext_wdata; ewe = ext_we; ere = !ext_we; end
    erd = ram[ea[7:2]];
    chk("cyc_cpu_ack", cpu_ack, m_owner == 1);
    chk("cyc_ext_ack", ext_ack, m_owner == 2);
    chk("cyc_mem_re", mem_re, ere);
    chk("cyc_mem_we", mem_we, ewe);
    chk("cyc_mem_addr", mem_addr, ea);
    chk("cyc_mem_wdata", mem_wdata, ed);
    chk("cyc_cpu_rdata", cpu_rdata, m_owner == 1 ? erd : 32'h0);
    chk("cyc_ext_rdata", ext_rdata, m_owner == 2 ? erd : 32'h0);
    chk("cyc_cpu_stall", cpu_stall, cpu_req && m_owner != 1);
`ifdef ARB_STATS_EN
    chk("cyc_cpu_wait", cpu_wait_cnt, 64'(m_cpu_wait));
    chk("cyc_ext_wait", ext_wait_cnt, 64'(m_ext_wait));
`else
    chk("cyc_cpu_wait", cpu_wait_cnt, 64'h0);
    chk("cyc_ext_wait", ext_wait_cnt, 64'h0);
`endif
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Single CPU access: checks no ack in the request cycle, ack one cycle later, then releases req
  task automatic cpu_single(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    step();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1 chk("cpu_latency_no_ack", cpu_ack, 1'b0);
    step();
    #1 chk("cpu_ack_next_cycle", cpu_ack, 1'b1);
    chk("cpu_mem_we_in_grant", mem_we, we);
    rdata = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [9:0]  seq;
    int          stall_cnt;

    #12;
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_wait", cpu_wait_cnt, 16'h0);
    reset = 1'b1;

    // CPU only: write then read back
    cpu_single(1'b1, 32'h8, 32'hDEADBEEF, rd);
    step();
    chk("cpu_we_one_cycle", mem_we, 1'b0);
    cpu_single(1'b0, 32'h8, 32'h0, rd);
    chk("cpu_read_back", rd, 32'hDEADBEEF);

    // Contention from IDLE: expect CPU x4, EXT, CPU x4, EXT
    step();
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h10;
    seq = '0; stall_cnt = 0;
    for (int g = 0; g < 10; g++) begin
      step();
      seq[g] = ext_ack;
      if (cpu_stall) stall_cnt++;
      chk("cont_one_owner", cpu_ack ^ ext_ack, 1'b1);
    end
    chk("cont_grant_seq", seq, 10'h210);
    chk("cont_stall_cycles", stall_cnt, 2);
    step();
`ifdef ARB_STATS_EN
    chk("stats_cpu_wait", cpu_wait_cnt, 16'd3);
    chk("stats_ext_wait", ext_wait_cnt, 16'd9);
`else
    chk("stats_cpu_wait", cpu_wait_cnt, 16'd0);
    chk("stats_ext_wait", ext_wait_cnt, 16'd0);
`endif
    cpu_req = 1'b0; ext_req = 1'b0;
    step();

    // EXT only, back-to-back writes at 0x0..0x1C
    step();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0; ext_wdata = 32'hA000_0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k > 1) begin ext_addr = 32'(4 * (k - 1)); ext_wdata = 32'hA000_0000 + 32'(k); end
      #1 chk("ext_b2b_ack", ext_ack, 1'b1);
      chk("ext_b2b_addr", mem_addr, 32'(4 * (k - 1)));
      if (k == 8) ext_req = 1'b0;
    end
    step();
    chk("ext_b2b_done", ext_ack, 1'b0);
    cpu_single(1'b0, 32'h0, 32'h0, rd);
    chk("ext_wr_first", rd, 32'hA000_0001);
    cpu_single(1'b0, 32'h1C, 32'h0, rd);
    chk("ext_wr_last", rd, 32'hA000_0008);

    // Reset asserted mid-write must suppress the write
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    step();
    #1 chk("rstw_we_before", mem_we, 1'b1);
    #1 reset = 1'b0;
    #1 chk("rstw_we_drop", mem_we, 1'b0);
    chk("rstw_ack_drop", cpu_ack, 1'b0);
    cpu_req = 1'b0;
    step();
    chk("rstw_ram_unchanged", ram[8], 32'h0);
    reset = 1'b1;
    step();
    chk("rstw_idle_after", {cpu_ack, ext_ack, mem_re}, 3'b000);
    cpu_single(1'b0, 32'h20, 32'h0, rd);
    chk("rstw_readback", rd, 32'h0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
